// File: rtl/clint_pkg.sv
// Shared types and CLINT register map for the register-port arbiter and its requesters.
package clint_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  // Address is carried at full 64 bits; narrower ports are zero-extended into it.
  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        lock;
  } port_req_t;

  localparam logic [63:0] MSIP_OFFSET     = 64'h0000;
  localparam logic [63:0] MTIMECMP_OFFSET = 64'h4000;
  localparam logic [63:0] MTIME_OFFSET    = 64'hbff8;

endpackage

// File: rtl/clint_rr_arbiter.sv
// Combinational round-robin picker: the first requester after ptr_i (wrapping) wins.
module clint_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int unsigned cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/clint_reg_arbiter.sv
// Round-robin arbiter with locked sequences in front of the CLINT register port.
// Optional stale-lock timeout is compiled in with CLINT_ARB_LOCK_TIMEOUT_EN.
module clint_reg_arbiter
  import clint_pkg::*;
#(
  parameter int unsigned NR_PORTS     = 2,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned LOCK_TIMEOUT = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NR_PORTS-1:0]                  req_i,
  input  logic [NR_PORTS-1:0]                  we_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0][63:0]            wdata_i,
  input  logic [NR_PORTS-1:0]                  lock_i,
  output logic [NR_PORTS-1:0]                  gnt_o,
  output logic [NR_PORTS-1:0]                  rvalid_o,
  output logic [63:0]                          rdata_o,
  output logic                                 en_o,
  output logic                                 we_o,
  output logic [ADDR_WIDTH-1:0]                address_o,
  output logic [63:0]                          wdata_o,
  input  logic [63:0]                          rdata_i
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NR_PORTS-1:0] rvalid_q, rvalid_d;
  logic [63:0]         rdata_q, rdata_d;

  port_req_t           port_req [NR_PORTS];
  port_req_t           sel;
  logic [NR_PORTS-1:0] owner_mask, arb_req, gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic                lock_timeout;

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      port_req[i] = '{we: we_i[i], addr: 64'(addr_i[i]), wdata: wdata_i[i], lock: lock_i[i]};
    end
  end

  // While locked the picker only sees the owner's request, so foreigners stall.
  assign arb_req = (state_q == LOCKED) ? (req_i & owner_mask) : req_i;

  clint_rr_arbiter #(
    .N     (NR_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign sel       = port_req[gnt_idx];
  assign gnt_o     = gnt;
  assign en_o      = gnt_valid;
  assign we_o      = gnt_valid & sel.we;
  assign address_o = gnt_valid ? ADDR_WIDTH'(sel.addr) : '0;
  assign wdata_o   = gnt_valid ? sel.wdata : '0;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;

`ifdef CLINT_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts owner-idle cycles while locked; an owner grant or unlocked state clears it.
  always_comb begin
    cnt_d = '0;
    if (state_q == LOCKED && !gnt_valid) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign lock_timeout = (state_q == LOCKED) && !gnt_valid && (cnt_d == CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^LOCK_TIMEOUT;
  assign lock_timeout        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    rvalid_d = gnt;
    rdata_d  = rdata_q;
    if (gnt_valid) begin
      rr_ptr_d = gnt_idx;
      owner_d  = gnt_idx;
      rdata_d  = sel.we ? '0 : rdata_i;
      state_d  = sel.lock ? LOCKED : UNLOCKED;
    end else if (lock_timeout) begin
      state_d = UNLOCKED;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= UNLOCKED;
      rr_ptr_q <= IDX_W'(NR_PORTS - 1);
      owner_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_clint_reg_arbiter.sv
// Self-checking bench for clint_reg_arbiter: directed table, lock/timeout/reset sequences,
// and randomized traffic against a behavioural round-robin/lock model.
module tb_clint_reg_arbiter;
  import clint_pkg::*;

  localparam int NR = 2;
  localparam int TO = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NR-1:0]         req_i, we_i, lock_i, gnt_o, rvalid_o;
  logic [NR-1:0][63:0]   addr_i, wdata_i;
  logic [63:0]           rdata_o, address_o, wdata_o, rdata_i;
  logic                  en_o, we_o;

  always #5 clk_i = ~clk_i;

  // Register file stand-in: mtime reads 0x10, everything else an address-derived pattern.
  function automatic logic [63:0] reg_model(input logic [63:0] a);
    if (a == MTIME_OFFSET) return 64'h10;
    return 64'hA5A5_0000_0000_0000 ^ a;
  endfunction

  assign rdata_i = reg_model(address_o);

  clint_reg_arbiter #(
    .NR_PORTS     (NR),
    .ADDR_WIDTH   (64),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .lock_i    (lock_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .en_o      (en_o),
    .we_o      (we_o),
    .address_o (address_o),
    .wdata_o   (wdata_o),
    .rdata_i   (rdata_i)
  );

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [63:0] a0, a1, w0, w1;
    logic [1:0]  gnt, rvalid;
    logic [63:0] rdata;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: last winner, lock owner, owner-idle cycle count.
  int m_last, m_owner, m_idle;
  bit m_locked;

  function automatic void model_reset();
    m_last = NR - 1; m_locked = 1'b0; m_owner = 0; m_idle = 0;
  endfunction

  function automatic int model_pick(input logic [1:0] req);
    int p;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NR; k++) begin
      p = (m_last + k) % NR;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic [1:0] req, we, lock, input logic [63:0] a0, a1, w0, w1,
                              input logic [1:0] gnt, rvalid, input logic [63:0] rdata);
    vec_t v;
    v.req = req; v.we = we; v.lock = lock; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    return v;
  endfunction

  // Called at posedge+1: drive, check combinational port mid-cycle, check response after the edge.
  task automatic run_cycle(input vec_t v, input bit use_model);
    int g, gi;
    logic [63:0] a [NR];
    logic [63:0] w [NR];
    logic [1:0]  exp_g;
    a[0] = v.a0; a[1] = v.a1; w[0] = v.w0; w[1] = v.w1;
    req_i = v.req; we_i = v.we; lock_i = v.lock;
    addr_i[0] = v.a0; addr_i[1] = v.a1; wdata_i[0] = v.w0; wdata_i[1] = v.w1;
    g = model_pick(v.req);
    if (use_model) begin
      exp_g    = (g < 0) ? 2'b00 : 2'(1 << g);
      v.rvalid = exp_g;
      v.rdata  = (g < 0) ? 64'h0 : (v.we[g] ? 64'h0 : reg_model(a[g]));
    end else begin
      exp_g = v.gnt;
    end
    gi = exp_g[1] ? 1 : 0;
    #4;
    check("gnt_o", gnt_o, exp_g);
    check("en_o", en_o, |exp_g);
    check("we_o", we_o, (exp_g != 0) ? v.we[gi] : 1'b0);
    check("address_o", address_o, (exp_g != 0) ? a[gi] : 64'h0);
    check("wdata_o", wdata_o, (exp_g != 0) ? w[gi] : 64'h0);
    @(posedge clk_i);
    #1;
    check("rvalid_o", rvalid_o, v.rvalid);
    if (v.rvalid != 0) check("rdata_o", rdata_o, v.rdata);
    if (g >= 0) begin
      m_last = g; m_owner = g; m_locked = v.lock[g]; m_idle = 0;
    end else if (m_locked) begin
      m_idle++;
`ifdef CLINT_ARB_LOCK_TIMEOUT_EN
      if (m_idle >= TO) begin
        m_locked = 1'b0; m_idle = 0;
      end
`endif
    end
  endtask

  vec_t        tbl [10];
  logic [1:0]  r_req, r_we, r_lock, pend;
  logic [63:0] r_a [NR];
  logic [63:0] r_w [NR];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(2'b01, 2'b00, 2'b00, 64'hbff8, 64'h0,    64'h0, 64'h0,    2'b01, 2'b01, 64'h10);
    tbl[1] = mk(2'b11, 2'b00, 2'b00, 64'h100,  64'h200,  64'h0, 64'h0,    2'b10, 2'b10, 64'hA5A5_0000_0000_0200);
    tbl[2] = mk(2'b11, 2'b00, 2'b00, 64'h100,  64'h200,  64'h0, 64'h0,    2'b01, 2'b01, 64'hA5A5_0000_0000_0100);
    tbl[3] = mk(2'b11, 2'b00, 2'b00, 64'h100,  64'h200,  64'h0, 64'h0,    2'b10, 2'b10, 64'hA5A5_0000_0000_0200);
    tbl[4] = mk(2'b11, 2'b00, 2'b00, 64'h100,  64'h200,  64'h0, 64'h0,    2'b01, 2'b01, 64'hA5A5_0000_0000_0100);
    tbl[5] = mk(2'b01, 2'b01, 2'b00, 64'h0,    64'h0,    64'h1, 64'h0,    2'b01, 2'b01, 64'h0);
    tbl[6] = mk(2'b11, 2'b10, 2'b10, 64'h8,    64'h4000, 64'h0, 64'h1111, 2'b10, 2'b10, 64'h0);
    tbl[7] = mk(2'b01, 2'b00, 2'b00, 64'h8,    64'h4000, 64'h0, 64'h0,    2'b00, 2'b00, 64'h0);
    tbl[8] = mk(2'b11, 2'b10, 2'b00, 64'h8,    64'h4004, 64'h0, 64'h2222, 2'b10, 2'b10, 64'h0);
    tbl[9] = mk(2'b01, 2'b00, 2'b00, 64'h8,    64'h0,    64'h0, 64'h0,    2'b01, 2'b01, 64'hA5A5_0000_0000_0008);

    req_i = '0; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0;
    rst_ni = 1'b0;
    model_reset();
    #12;
    check("reset gnt_o", gnt_o, 64'h0);
    check("reset en_o", en_o, 64'h0);
    check("reset address_o", address_o, 64'h0);
    check("reset rvalid_o", rvalid_o, 64'h0);
    check("reset rdata_o", rdata_o, 64'h0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (tbl[i]) run_cycle(tbl[i], 1'b0);

    // Port 0 locks then goes idle while port 1 waits.
    run_cycle(mk(2'b01, 2'b00, 2'b01, MSIP_OFFSET, 64'h0, 64'h0, 64'h0,
                 2'b01, 2'b01, 64'hA5A5_0000_0000_0000), 1'b0);
`ifdef CLINT_ARB_LOCK_TIMEOUT_EN
    for (int k = 1; k <= TO + 1; k++) begin
      run_cycle(mk(2'b10, 2'b00, 2'b00, 64'h0, MTIME_OFFSET, 64'h0, 64'h0,
                   (k == TO + 1) ? 2'b10 : 2'b00, (k == TO + 1) ? 2'b10 : 2'b00, 64'h10), 1'b0);
    end
`else
    for (int k = 1; k <= TO + 4; k++) begin
      run_cycle(mk(2'b10, 2'b00, 2'b00, 64'h0, MTIME_OFFSET, 64'h0, 64'h0,
                   2'b00, 2'b00, 64'h0), 1'b0);
    end
    run_cycle(mk(2'b11, 2'b00, 2'b00, MSIP_OFFSET, MTIME_OFFSET, 64'h0, 64'h0,
                 2'b01, 2'b01, 64'hA5A5_0000_0000_0000), 1'b0);
    run_cycle(mk(2'b10, 2'b00, 2'b00, 64'h0, MTIME_OFFSET, 64'h0, 64'h0,
                 2'b10, 2'b10, 64'h10), 1'b0);
`endif

    // Reset while locked with a response pending and a grant in flight.
    run_cycle(mk(2'b01, 2'b00, 2'b01, MTIME_OFFSET, 64'h0, 64'h0, 64'h0,
                 2'b01, 2'b01, 64'h10), 1'b0);
    req_i = 2'b01; lock_i = 2'b01; addr_i[0] = MSIP_OFFSET;
    #2;
    req_i = '0; lock_i = '0;
    rst_ni = 1'b0;
    #1;
    check("rst gnt_o", gnt_o, 64'h0);
    check("rst en_o", en_o, 64'h0);
    check("rst we_o", we_o, 64'h0);
    check("rst address_o", address_o, 64'h0);
    check("rst wdata_o", wdata_o, 64'h0);
    check("rst rvalid_o", rvalid_o, 64'h0);
    check("rst rdata_o", rdata_o, 64'h0);
    @(posedge clk_i);
    #1;
    check("rst no rvalid", rvalid_o, 64'h0);
    #3;
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    run_cycle(mk(2'b10, 2'b00, 2'b00, 64'h0, MTIME_OFFSET, 64'h0, 64'h0,
                 2'b10, 2'b10, 64'h10), 1'b0);

    // Randomized traffic; a waiting requester holds its request unchanged until granted.
    pend = '0; r_req = '0; r_we = '0; r_lock = '0;
    r_a[0] = '0; r_a[1] = '0; r_w[0] = '0; r_w[1] = '0;
    for (int n = 0; n < 400; n++) begin
      int g;
      for (int p = 0; p < NR; p++) begin
        if (!pend[p]) begin
          r_req[p]  = ($urandom_range(0, 3) != 0);
          r_we[p]   = 1'($urandom_range(0, 1));
          r_lock[p] = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 4))
            0:       r_a[p] = MSIP_OFFSET;
            1:       r_a[p] = MTIMECMP_OFFSET;
            2:       r_a[p] = MTIMECMP_OFFSET + 64'h4;
            3:       r_a[p] = MTIME_OFFSET;
            default: r_a[p] = {$urandom, $urandom};
          endcase
          r_w[p] = {$urandom, $urandom};
        end
      end
      g = model_pick(r_req);
      run_cycle(mk(r_req, r_we, r_lock, r_a[0], r_a[1], r_w[0], r_w[1], 2'b00, 2'b00, 64'h0), 1'b1);
      for (int p = 0; p < NR; p++) pend[p] = r_req[p] && (g != p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clint_reg_arbiter.md
# clint_reg_arbiter

Round-robin arbiter and sequencer that shares the CLINT register port (en/we/address/wdata/rdata) between several on-chip requesters, e.g. the AXI-Lite front end and the debug module. It grants at most one access per cycle and returns the read data with fixed one-cycle latency. It supports locked access sequences so that a requester can perform multi-access read-modify-write or split 32-bit mtime/mtimecmp updates atomically. It sits directly in front of the CLINT register logic and drives its en/we/address/wdata inputs.

## Interface
- NR_PORTS, 2, number of requesters (>= 2)
- ADDR_WIDTH, 64, address width on all ports
- LOCK_TIMEOUT, 256, idle cycles before a stale lock is dropped (timeout build only)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NR_PORTS  per-port access request
- we_i  in  NR_PORTS  per-port write enable
- addr_i  in  NR_PORTS x ADDR_WIDTH  per-port address
- wdata_i  in  NR_PORTS x 64  per-port write data
- lock_i  in  NR_PORTS  keep ownership after this access
- gnt_o  out  NR_PORTS  one-hot grant, same cycle as req
- rvalid_o  out  NR_PORTS  response valid, one cycle after gnt
- rdata_o  out  64  response data, shared by all ports
- en_o  out  1  register-port enable
- we_o  out  1  register-port write enable
- address_o  out  ADDR_WIDTH  register-port address
- wdata_o  out  64  register-port write data
- rdata_i  in  64  register-port read data, combinational from en_o/address_o

## Operation
- Unlocked: grant is combinational. Priority starts at the port after the last granted port (rr_ptr) and wraps modulo NR_PORTS. If no port requests, gnt_o = 0 and en_o = 0.
- Granted port i: en_o=1, we_o/address_o/wdata_o = port i's values. At the clock edge, rdata_o <= we ? 0 : rdata_i, rvalid_o <= one-hot(i), and rr_ptr <= i.
- Granted with lock_i[i]=1: the state goes LOCKED with owner=i. While LOCKED, only the owner can be granted, and other requests stall (gnt=0).
- Granted owner access with lock_i=0: state returns to UNLOCKED after the edge. Normal round-robin applies from the next cycle.
- Owner requesting with lock_i=1 again keeps LOCKED. There is no limit on sequence length.
- Requests are level-held until granted; a requester must not change we/addr/wdata while req is high and ungranted.

## Timing
- Reset values: gnt_o=0, en_o=0, we_o=0, address_o=0, wdata_o=0, rvalid_o=0, rdata_o=0, rr_ptr=NR_PORTS-1 (so port 0 wins first), state UNLOCKED, timeout counter 0.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed only when it is the sole requester or the lock owner.
- Read latency: rdata_o and rvalid_o are valid exactly 1 cycle after gnt. rvalid_o is a single-cycle pulse per grant, for both reads and writes.
- Simultaneous lock release and foreign request: the foreign request waits until the cycle after the releasing grant.
- Reset asserted mid-lock or with a response pending: everything clears asynchronously; no rvalid is issued for the interrupted access.

## Configuration
- CLINT_ARB_LOCK_TIMEOUT_EN defined:
  - While LOCKED, a counter increments on every cycle in which the owner is not granted.
  - The counter clears on an owner grant.
  - When it reaches LOCK_TIMEOUT, state goes UNLOCKED next cycle.
  - The counter is $clog2(LOCK_TIMEOUT+1) bits and saturates.
- Not defined: the lock holds until released by the owner; the counter logic is absent.

## Structure
- The shared package clint_pkg holds:
  - the state enum (UNLOCKED, LOCKED)
  - the per-port request struct (we, addr, wdata, lock)
  - the CLINT register offsets (MSIP 0x0, MTIMECMP 0x4000, MTIME 0xbff8), so requesters and the arbiter agree
- Sub-module clint_rr_arbiter: a purely combinational round-robin picker taking req vector and rr_ptr and returning a one-hot grant plus index. It is reused for the masked-to-owner case by passing only the owner's req bit.

## Test plan
- Reset, then port 0 reads 0xbff8 with mtime=0x10 → gnt_o=01 same cycle, next cycle rvalid_o=01, rdata_o=0x10.
- Ports 0 and 1 requesting continuously (unlocked) → grants alternate 01,10,01,10…, each followed by a one-cycle rvalid pulse to the same port.
- Port 1 locks, writes 0x4000 low and then 0x4004 high (lock=1 then 0) while port 0 requests → port 0 gets gnt only on the cycle after port 1's second grant.
- Write to 0x0 with wdata=1 → en_o=1, we_o=1, address_o=0x0, wdata_o=1; rvalid next cycle with rdata_o=0.
- With CLINT_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=4: port 0 locks and then drops req, port 1 requests → port 1 is granted 5 cycles after the locking grant. Without the macro, port 1 is never granted.
- rst_ni pulsed low while LOCKED with an rvalid pending → all outputs 0 immediately, and port 1 is granted on the first request after reset.
